reset_seq_ctl: RTL

RESET_SEQ_CTL -- requirements
Module: reset_seq_ctl

---
 rtl/rst_seq_pkg.sv | 24 ++
 rtl/areset_sync.sv | 34 +++
 rtl/reset_seq_ctl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/rst_seq_pkg.sv
// ----------------------------------------------------------------------------
// rst_seq_pkg : shared types and helpers for the reset sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'b00,
    ST_RELEASE = 2'b01,
    ST_RUN     = 2'b10
  } rst_seq_state_e;

  localparam logic [1:0] c_cause_ext  = 2'b01;
  localparam logic [1:0] c_cause_soft = 2'b10;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/areset_sync.sv
// ----------------------------------------------------------------------------
// areset_sync : asynchronous-assert, synchronous-release reset synchroniser
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module areset_sync #(
  parameter int RST_POL = 0,
  parameter int STAGES  = 2
) (
  input  logic clk,
  input  logic i_arst,
  output logic o_rst
);

  logic [STAGES-1:0] r_sync;

  if (RST_POL == 0) begin : g_active_low
    always_ff @(posedge clk or negedge i_arst) begin
      if (!i_arst) r_sync <= '0;
      else         r_sync <= {r_sync[STAGES-2:0], 1'b1};
    end
  end else begin : g_active_high
    always_ff @(posedge clk or posedge i_arst) begin
      if (i_arst) r_sync <= '1;
      else        r_sync <= {r_sync[STAGES-2:0], 1'b0};
    end
  end

  assign o_rst = r_sync[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/reset_seq_ctl.sv
// ----------------------------------------------------------------------------
// reset_seq_ctl : staggered release of NUM_RST synchronous resets
// Optional macro RESET_SEQ_CAUSE_EN adds the o_rst_cause output.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module reset_seq_ctl
  import rst_seq_pkg::*;
#(
  parameter int NUM_RST     = 3,
  parameter int SYNC_STAGES = 2,
  parameter int GAP_CYCLES  = 4,
  parameter int HOLD_CYCLES = 8
) (
  input  logic               clk,
  input  logic               i_ext_resetn_async,
  input  logic               i_soft_rst_req,
  output logic [NUM_RST-1:0] o_resetn_sync,
  output logic               o_seq_done,
`ifdef RESET_SEQ_CAUSE_EN
  output logic               o_busy,
  output logic [1:0]         o_rst_cause
`else
  output logic               o_busy
`endif
);

  localparam int c_cnt_w = $clog2(max2(GAP_CYCLES, HOLD_CYCLES) + 1);
  localparam logic [c_cnt_w-1:0] c_hold_term = c_cnt_w'(HOLD_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_gap_term  = c_cnt_w'(GAP_CYCLES - 1);
  localparam logic [NUM_RST-1:0] c_first     = NUM_RST'(1);

  if (NUM_RST < 1 || NUM_RST > 8) begin : g_bad_num_rst
    $error("reset_seq_ctl: NUM_RST out of range 1..8");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 8) begin : g_bad_sync_stages
    $error("reset_seq_ctl: SYNC_STAGES out of range 2..8");
  end
  if (GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_bad_gap
    $error("reset_seq_ctl: GAP_CYCLES out of range 1..255");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("reset_seq_ctl: HOLD_CYCLES out of range 1..255");
  end

  logic                 w_sync_rstn;
  logic [NUM_RST-1:0]   w_next_resetn;
  rst_seq_state_e       r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_cnt_w-1:0]   r_hold_term;
  logic [NUM_RST-1:0]   r_resetn;
  logic                 r_seq_done;
  logic                 r_busy;

  areset_sync #(
    .RST_POL (0),
    .STAGES  (SYNC_STAGES)
  ) u_areset_sync (
    .clk    (clk),
    .i_arst (i_ext_resetn_async),
    .o_rst  (w_sync_rstn)
  );

  // Outputs release as a thermometer code filling from bit 0 upward.
  assign w_next_resetn = (r_resetn << 1) | c_first;

  always_ff @(posedge clk or negedge i_ext_resetn_async) begin
    if (!i_ext_resetn_async) begin
      r_state     <= ST_HOLD;
      r_cnt       <= '0;
      r_hold_term <= '0;
      r_resetn    <= '0;
      r_seq_done  <= 1'b0;
      r_busy      <= 1'b1;
    end else if (!w_sync_rstn) begin
      r_state     <= ST_HOLD;
      r_cnt       <= '0;
      r_hold_term <= '0;
      r_resetn    <= '0;
      r_seq_done  <= 1'b0;
      r_busy      <= 1'b1;
    end else if (i_soft_rst_req) begin
      r_state     <= ST_HOLD;
      r_cnt       <= '0;
      r_hold_term <= c_hold_term;
      r_resetn    <= '0;
      r_seq_done  <= 1'b0;
      r_busy      <= 1'b1;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (r_cnt == r_hold_term) begin
            r_resetn <= c_first;
            r_cnt    <= '0;
            if (NUM_RST == 1) begin
              r_state    <= ST_RUN;
              r_seq_done <= 1'b1;
              r_busy     <= 1'b0;
            end else begin
              r_state <= ST_RELEASE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (r_cnt == c_gap_term) begin
            r_resetn <= w_next_resetn;
            r_cnt    <= '0;
            if (w_next_resetn[NUM_RST-1]) begin
              r_state    <= ST_RUN;
              r_seq_done <= 1'b1;
              r_busy     <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          r_cnt <= '0;
        end
        default: begin
          r_state  <= ST_HOLD;
          r_cnt    <= '0;
          r_resetn <= '0;
          r_busy   <= 1'b1;
        end
      endcase
    end
  end

  assign o_resetn_sync = r_resetn;
  assign o_seq_done    = r_seq_done;
  assign o_busy        = r_busy;

`ifdef RESET_SEQ_CAUSE_EN
  logic [1:0] r_rst_cause;

  // Soft requests are only accepted once the synchronised reset is released.
  always_ff @(posedge clk or negedge i_ext_resetn_async) begin
    if (!i_ext_resetn_async) begin
      r_rst_cause <= c_cause_ext;
    end else if (w_sync_rstn && i_soft_rst_req) begin
      r_rst_cause <= c_cause_soft;
    end
  end

  assign o_rst_cause = r_rst_cause;
`endif

endmodule

`default_nettype wire
